// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR chain sequencer and its sample FIFO.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } fir_state_e;

    localparam int DATA_W_DEF    = 16;
    localparam int TAP_W_DEF     = 4;
    localparam int DEPTH_DEF     = 15;
    localparam int FLUSH_LEN_DEF = 2 * DEPTH_DEF;

    // Both shifters must be fully overwritten with zeros after a tap change.
    function automatic int flush_len(input int depth);
        return 2 * depth;
    endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Small synchronous sample FIFO; the head word is visible combinationally.
module fir_sample_fifo
    import fir_ctrl_pkg::*;
#(
    parameter int W = DATA_W_DEF,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == CW'(D));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; pointers wrap modulo D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_chain_sequencer.sv
// Sequences samples through the lowpass/highpass FIR chain and owns the shared
// tap select, zero-flushing both shifters whenever the tap changes.
module fir_chain_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TAP_W      = TAP_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAP_RST    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAP_W-1:0]  tap_req,
    input  logic              tap_req_valid,
    output logic              tap_req_ready,
    output logic              tap_done,
    output logic [TAP_W-1:0]  tap,
    output logic              shift_en,
    output logic [DATA_W-1:0] sample_out,
    input  logic [DATA_W-1:0] filt_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int FLUSH_CYC = flush_len(DEPTH);
    localparam int CNT_W     = $clog2(FLUSH_CYC);

    fir_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic              pend_q, pend_d;
    logic [TAP_W-1:0]  pend_tap_q, pend_tap_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              shift_en_q, shift_en_d;
    logic [DATA_W-1:0] sample_out_q, sample_out_d;
    logic              tap_done_q, tap_done_d;

    logic              push_s;
    logic              pop_s;
    logic              capture_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign push_s = in_valid && !fifo_full_s;

    fir_sample_fifo #(
        .W (DATA_W),
        .D (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_s),
        .data_i  (in_data),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next-state logic for the sequencer, tap holding registers and result register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tap_d        = tap_q;
        pend_d       = pend_q;
        pend_tap_d   = pend_tap_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        tap_done_d   = 1'b0;
        pop_s        = 1'b0;
        capture_s    = 1'b0;

        if (tap_req_valid && !pend_q) begin
            pend_d     = 1'b1;
            pend_tap_d = tap_req;
        end else begin
            pend_d     = pend_q;
        end

        case (state_q)
            IDLE: begin
                // A pending tap change outranks queued samples.
                if (pend_q) begin
                    tap_d   = pend_tap_q;
                    pend_d  = 1'b0;
                    cnt_d   = CNT_W'(FLUSH_CYC - 1);
                    state_d = FLUSH;
                end else if (!fifo_empty_s && (!out_valid_q || out_ready)) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                pop_s   = 1'b1;
                cnt_d   = CNT_W'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    capture_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            FLUSH: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    tap_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A capture on the same edge as a consumer accept keeps valid high.
        if (capture_s) begin
            out_valid_d = 1'b1;
            out_data_d  = filt_in;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        shift_en_d   = (state_d == SHIFT) || (state_d == FLUSH);
        sample_out_d = (state_d == SHIFT) ? fifo_head_s : {DATA_W{1'b0}};
    end

    // State and output registers; outputs are registered from next-state decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            tap_q        <= TAP_W'(TAP_RST);
            pend_q       <= 1'b0;
            pend_tap_q   <= {TAP_W{1'b0}};
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            shift_en_q   <= 1'b0;
            sample_out_q <= {DATA_W{1'b0}};
            tap_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            pend_q       <= pend_d;
            pend_tap_q   <= pend_tap_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            shift_en_q   <= shift_en_d;
            sample_out_q <= sample_out_d;
            tap_done_q   <= tap_done_d;
        end
    end

    assign in_ready      = !fifo_full_s;
    assign tap_req_ready = !pend_q;
    assign tap_done      = tap_done_q;
    assign tap           = tap_q;
    assign shift_en      = shift_en_q;
    assign sample_out    = sample_out_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign busy          = (state_q != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_fir_chain_sequencer.sv
// Directed bench for fir_chain_sequencer; the datapath stand-in outputs the
// bitwise inverse of the most recently shifted word.
module tb_fir_chain_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  tap_req = 4'h0;
    logic        tap_req_valid = 1'b0;
    logic        tap_req_ready;
    logic        tap_done;
    logic [3:0]  tap;
    logic        shift_en;
    logic [15:0] sample_out;
    logic [15:0] filt_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    fir_chain_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .tap_req       (tap_req),
        .tap_req_valid (tap_req_valid),
        .tap_req_ready (tap_req_ready),
        .tap_done      (tap_done),
        .tap           (tap),
        .shift_en      (shift_en),
        .sample_out    (sample_out),
        .filt_in       (filt_in),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] dp_q;
    always @(posedge clk or negedge rst) begin
        if (!rst) dp_q <= 16'h0;
        else if (shift_en) dp_q <= sample_out;
    end
    assign filt_in = ~dp_q;

    logic [15:0] shift_log[$];
    int          shift_cyc[$];
    logic [3:0]  tap_log[$];
    logic [15:0] out_log[$];
    int          out_cyc[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (shift_en && sample_out != 16'h0) begin
            shift_log.push_back(sample_out);
            shift_cyc.push_back(cyc);
            tap_log.push_back(tap);
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        if (tap_done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input string tag, input int base, input int n, input int budget);
        int k;
        k = 0;
        while ((out_log.size() - base) < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'((out_log.size() - base) >= n), 32'd1);
    endtask

    logic [15:0] burst [6] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};

    initial begin
        int base_s, base_o, base_d, k0, j, k, first_drop_j, zcnt, run, tdc;
        bit acc, saw_full, still_on, stable;
        logic [15:0] exp16;

        // Reset state
        tick(3);
        check("rst_shift_en", shift_en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tap", tap, 4'h0);
        rst = 1'b1;
        tick(1);
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_tap_req_ready", tap_req_ready, 1'b1);
        check("rel_sample_out", sample_out, 16'h0);
        check("rel_out_data", out_data, 16'h0);
        check("rel_tap_done", tap_done, 1'b0);

        // Single sample latency
        base_s = shift_log.size();
        in_data = 16'h1234;
        in_valid = 1'b1;
        tick(1);
        k0 = cyc;
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            if (i == 1) begin
                check("t1_shift_en_on", shift_en, 1'b1);
                check("t1_sample_out", sample_out, 16'h1234);
            end
            if (i == 2) check("t1_shift_en_off", shift_en, 1'b0);
            check($sformatf("t1_out_valid_k%0d", i), out_valid, 32'(i == 4));
        end
        check("t1_out_data", out_data, 16'hEDCB);
        check("t1_shift_count", shift_log.size() - base_s, 32'd1);
        check("t1_shift_cycle", shift_cyc[base_s], k0 + 1);
        tick(1);
        check("t1_out_valid_clr", out_valid, 1'b0);
        check("t1_busy_idle", busy, 1'b0);

        // Burst of 6 with in_valid held
        base_s = shift_log.size();
        base_o = out_log.size();
        j = 0; k = 0; saw_full = 0; first_drop_j = -1;
        while (j < 6 && k < 100) begin
            in_data = burst[j];
            in_valid = 1'b1;
            acc = in_ready;
            if (!in_ready && !saw_full) begin
                saw_full = 1;
                first_drop_j = j;
            end
            tick(1);
            if (acc) j++;
            k++;
        end
        in_valid = 1'b0;
        check("t2_in_ready_dropped", saw_full, 1'b1);
        check("t2_drop_point", first_drop_j, 32'd5);
        wait_outs("t2_timeout", base_o, 6, 200);
        for (int i = 0; i < 6; i++) begin
            if (out_log.size() > base_o + i && shift_log.size() > base_s + i) begin
                check($sformatf("t2_shift_%0d", i), shift_log[base_s + i], burst[i]);
                exp16 = ~burst[i];
                check($sformatf("t2_out_%0d", i), out_log[base_o + i], exp16);
                if (i > 0)
                    check($sformatf("t2_spacing_%0d", i),
                          out_cyc[base_o + i] - out_cyc[base_o + i - 1], 32'd4);
            end
        end
        tick(3);

        // Back-pressure after first result
        out_ready = 1'b0;
        base_s = shift_log.size();
        base_o = out_log.size();
        in_data = 16'h1111;
        in_valid = 1'b1;
        tick(1);
        in_data = 16'h2222;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        check("t3_out_valid", out_valid, 1'b1);
        stable = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (out_data !== 16'hEEEE || shift_en !== 1'b0 || out_valid !== 1'b1) stable = 0;
        end
        check("t3_hold_stable", stable, 1'b1);
        check("t3_single_shift", shift_log.size() - base_s, 32'd1);
        check("t3_out_data", out_data, 16'hEEEE);
        out_ready = 1'b1;
        tick(1);
        check("t3_resume_shift_en", shift_en, 1'b1);
        check("t3_resume_sample", sample_out, 16'h2222);
        wait_outs("t3_timeout", base_o, 2, 50);
        if (out_log.size() >= base_o + 2) begin
            check("t3_out0", out_log[base_o], 16'hEEEE);
            check("t3_out1", out_log[base_o + 1], 16'hDDDD);
        end
        tick(3);

        // Tap change while idle
        check("t4_idle", busy, 1'b0);
        base_d = done_cnt;
        tap_req = 4'd5;
        tap_req_valid = 1'b1;
        tick(1);
        tap_req_valid = 1'b0;
        check("t4_req_ready_low", tap_req_ready, 1'b0);
        check("t4_tap_old", tap, 4'd0);
        tick(1);
        check("t4_tap_new", tap, 4'd5);
        check("t4_req_ready_back", tap_req_ready, 1'b1);
        zcnt = (shift_en && sample_out == 16'h0) ? 1 : 0;
        run = zcnt;
        still_on = (zcnt == 1);
        tdc = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (shift_en && sample_out == 16'h0) zcnt++;
            if (shift_en && still_on) run++;
            else still_on = 0;
            if (tap_done) tdc++;
        end
        check("t4_flush_total", zcnt, 32'd30);
        check("t4_flush_contig", run, 32'd30);
        check("t4_tap_done_once", tdc, 32'd1);
        check("t4_no_capture", out_valid, 1'b0);

        // Tap request during WAIT with two samples queued
        base_s = shift_log.size();
        base_o = out_log.size();
        base_d = done_cnt;
        in_valid = 1'b1;
        in_data = 16'h0A0A;
        tick(1);
        in_data = 16'h0B0B;
        tick(1);
        in_data = 16'h0C0C;
        tick(1);
        in_valid = 1'b0;
        tap_req = 4'd9;
        tap_req_valid = 1'b1;
        tick(1);
        tap_req_valid = 1'b0;
        k = 0;
        while (tap !== 4'd9 && k < 20) begin
            tick(1);
            k++;
        end
        check("t5_tap_loaded", tap, 4'd9);
        check("t5_first_captured", out_log.size() - base_o, 32'd1);
        check("t5_one_shift_before", shift_log.size() - base_s, 32'd1);
        wait_outs("t5_timeout", base_o, 3, 200);
        if (out_log.size() >= base_o + 3 && shift_log.size() >= base_s + 3) begin
            check("t5_out0", out_log[base_o], 16'hF5F5);
            check("t5_shift1", shift_log[base_s + 1], 16'h0B0B);
            check("t5_shift2", shift_log[base_s + 2], 16'h0C0C);
            check("t5_tap1", tap_log[base_s + 1], 4'd9);
            check("t5_tap2", tap_log[base_s + 2], 4'd9);
            check("t5_out1", out_log[base_o + 1], 16'hF4F4);
            check("t5_out2", out_log[base_o + 2], 16'hF3F3);
        end
        check("t5_tap_done", done_cnt - base_d, 32'd1);
        tick(3);

        // Reset in the middle of a flush
        out_ready = 1'b0;
        in_data = 16'h0D0D;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(4);
        check("t6_result_held", out_valid, 1'b1);
        tap_req = 4'd3;
        tap_req_valid = 1'b1;
        tick(1);
        tap_req_valid = 1'b0;
        tick(1);
        tick(5);
        in_data = 16'h0E0E;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        check("t6_in_flush", shift_en, 1'b1);
        check("t6_busy_pre", busy, 1'b1);
        check("t6_tap_pre", tap, 4'd3);
        rst = 1'b0;
        #1;
        check("t6_shift_en_rst", shift_en, 1'b0);
        check("t6_out_valid_rst", out_valid, 1'b0);
        check("t6_busy_rst", busy, 1'b0);
        check("t6_tap_rst", tap, 4'd0);
        check("t6_sample_out_rst", sample_out, 16'h0);
        tick(2);
        rst = 1'b1;
        base_s = shift_log.size();
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (shift_en !== 1'b0 || busy !== 1'b0) stable = 0;
        end
        check("t6_stays_idle", stable, 1'b1);
        check("t6_no_shift", shift_log.size() - base_s, 32'd0);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_tap_req_ready", tap_req_ready, 1'b1);
        check("t6_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
